serial_addsub_demux: RTL and testbench
======================================

# serial_addsub_demux

Bit-serial, WIDTH-bit adder/subtractor. One bit slice is computed per clock by a 1x8 demux decode of {a_bit, b_bit, carry/borrow}, generalising the single-bit demux-based full adder and full subtractor to N bits with a runtime add/subtract mode. A start/busy/done handshake brackets each operation. The block sits beside the combinational demux adders as the area-minimal multi-bit arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits (legal range 2..32)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = add (a+b), 1 = subtract (a−b); latched with operands
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference; holds until next accepted start
- cout  output  1  final carry (add) or borrow (sub); holds with result
- ovf  output  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → latch a, b, mode into shift registers; clear carry FF, bit counter and result register; → RUN. start=0 → stay.
- RUN, each cycle: sel = {a_sh[0], b_sh[0], cy}; 1x8 demux (data tied 1) yields one-hot y[7:0].
  - Bit out (both modes) = y1|y2|y4|y7.
  - Add: next cy = y3|y5|y6|y7. Sub: next cy (borrow) = y1|y2|y3|y7.
  - Bit out shifts into result MSB, result shifts right; a_sh, b_sh shift right; counter increments.
  - After WIDTH slices (counter = WIDTH−1 on that edge) → DONE; cout ← final cy.
- DONE: done=1 for exactly one cycle → IDLE unconditionally. start in DONE is ignored.
- start while busy or in DONE: ignored; no queuing.
- Arithmetic: result = (a ± b) mod 2^WIDTH. cout = unsigned carry-out (add) or borrow, i.e. a<b unsigned (sub).
- Operand inputs may change freely after the accepting edge.
- rst during RUN/DONE: operation aborted, all state and outputs cleared next edge; no done pulse.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, state IDLE, counter=0, cy=0.
- Start accepted at edge k → busy=1 from edge k through edge k+WIDTH (WIDTH cycles).
- done=1 in the cycle after edge k+WIDTH; low after edge k+WIDTH+1.
- result and cout valid and stable from edge k+WIDTH until the next accepted start.
- Next accepted start at edge k+WIDTH+2 at the earliest (throughput WIDTH+2 cycles/op).
- busy and done are never high together; all outputs are registered.
- Counter width is $clog2(WIDTH); no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: ovf port exists. Carry into the MSB slice is registered; on the final slice, ovf ← cy_in(MSB) XOR cy_out(MSB). ovf updates with cout and holds with result. Reset value 0.
- SERIAL_ADDSUB_OVF_EN undefined: no ovf port, no MSB-carry register; all other behaviour identical.

## Test plan
- WIDTH=8, add 8'h3C+8'h05 → result 8'h41, cout 0, ovf 0; done exactly 9 cycles after the start edge; busy high for 8 cycles.
- Add 8'hFF+8'h01 → result 8'h00, cout 1, ovf 0; add 8'h7F+8'h01 → 8'h80, cout 0, ovf 1.
- Sub 8'h05−8'h09 → result 8'hFC, cout (borrow) 1, ovf 0; sub 8'h80−8'h01 → 8'h7F, cout 0, ovf 1.
- Start pulsed again mid-RUN with different operands and mode → ignored; first result unchanged, single done pulse; back-to-back start at the earliest legal edge accepted.
- rst asserted at cycle 4 of RUN → next edge: busy 0, done 0, result 0, cout 0; no done pulse; a following op completes correctly.
- Rebuild without SERIAL_ADDSUB_OVF_EN, WIDTH=16: 16'hFFFF+16'h0001 → 16'h0000, cout 1; done 17 cycles after start.

Source files
------------

// File: rtl/serial_addsub_demux.sv
// Bit-serial WIDTH-bit adder/subtractor, one demux-decoded slice per clock.
// Optional signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [2:0] sel;
  logic [7:0] y;
  logic       bit_o;
  logic       cy_nx;
  logic       last;

  // 1x8 demux with data tied high; sum/diff and carry/borrow are OR-taps
  always_comb begin
    sel   = {a_sh_q[0], b_sh_q[0], cy_q};
    y     = 8'd1 << sel;
    bit_o = y[1] | y[2] | y[4] | y[7];
    cy_nx = mode_q ? (y[1] | y[2] | y[3] | y[7])
                   : (y[3] | y[5] | y[6] | y[7]);
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          cy_d    = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {bit_o, res_q[WIDTH-1:1]};
        cy_d   = cy_nx;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          cout_d  = cy_nx;
`ifdef SERIAL_ADDSUB_OVF_EN
          // cy_q is the carry into the MSB slice here
          ovf_d   = cy_q ^ cy_nx;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_demux.sv
// Randomized bench for serial_addsub_demux against a behavioural model.
// Checks ovf as well when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_demux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf_w;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_demux #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf_w)
`endif
  );

`ifndef SERIAL_ADDSUB_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: operation outcome computed arithmetically at accept
  logic         m_busy = 0, m_done = 0, m_valid = 0;
  int           m_left = 0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_cout = 0, p_cout = 0;
  logic         m_ovf = 0, p_ovf = 0;

  always @(posedge clk) begin
    logic [W:0]   s;
    logic [W-1:0] r;
    if (rst) begin
      m_busy  <= 0;
      m_done  <= 0;
      m_valid <= 1;
      m_res   <= '0;
      m_cout  <= 0;
      m_ovf   <= 0;
    end else if (!m_busy && !m_done) begin
      if (start) begin
        if (mode) begin
          r = a - b;
          p_cout <= (a < b);
          p_ovf  <= (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
          s = {1'b0, a} + {1'b0, b};
          r = s[W-1:0];
          p_cout <= s[W];
          p_ovf  <= (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        p_res   <= r;
        m_busy  <= 1;
        m_left  <= W;
        m_valid <= 0;
      end
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 0;
        m_done  <= 1;
        m_res   <= p_res;
        m_cout  <= p_cout;
        m_ovf   <= p_ovf;
        m_valid <= 1;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (busy && done) chk("busy_and_done", 1, 0);
    if (m_valid) begin
      chk("result", 32'(result), 32'(m_res));
      chk("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
      chk("ovf", 32'(ovf_w), 32'(m_ovf));
`endif
    end
  end

  // inj: 0 none, 1 stray start mid-run, 2 reset in run
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tm, input int inj,
                        input logic [W-1:0] er, input logic ec,
                        input logic eo, output int acc_wait);
    int n;
    a = ta; b = tb; mode = tm; start = 1;
    acc_wait = 0;
    do begin
      @(posedge clk); #1;
      acc_wait++;
    end while (!busy && acc_wait < 20);
    start = 0;
    a = ~ta; b = ~tb; mode = ~tm;
    if (!busy) chk("accept_timeout", 0, 1);
    n = 0;
    do begin
      if (inj == 1 && n == 3) begin
        start = 1; a = 8'h11; b = 8'h22; mode = ~tm;
      end else start = 0;
      if (inj == 2 && n == 4) rst = 1;
      @(posedge clk); #1;
      n++;
      if (inj == 2 && rst) begin
        rst = 0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf", 32'(ovf_w), 0);
        repeat (W + 2) begin
          @(posedge clk); #1;
          chk("rst_no_done", 32'(done), 0);
        end
        return;
      end
    end while (!done && n < 40);
    start = 0;
    chk("latency", n, W);
    chk("lit_result", 32'(result), 32'(er));
    chk("lit_cout", 32'(cout), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("lit_ovf", 32'(ovf_w), 32'(eo));
`else
    if (eo === 1'bx) chk("lit_ovf_x", 0, 1);
`endif
  endtask

  initial begin
    int w;
    int gap;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_cout", 32'(cout), 0);
    @(posedge clk); #1;

    run_op(8'h3C, 8'h05, 0, 0, 8'h41, 0, 0, w);
    chk("idle_accept", w, 1);
    run_op(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, w);
    chk("b2b_accept", w, 2);
    run_op(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, w);
    run_op(8'h05, 8'h09, 1, 0, 8'hFC, 1, 0, w);
    run_op(8'h80, 8'h01, 1, 0, 8'h7F, 0, 1, w);
    run_op(8'h10, 8'h20, 0, 1, 8'h30, 0, 0, w);
    repeat (3) begin
      @(posedge clk); #1;
      chk("single_done", 32'(done), 0);
    end
    run_op(8'hA5, 8'h5A, 0, 2, 8'h00, 0, 0, w);
    run_op(8'h12, 8'h34, 1, 0, 8'hDE, 1, 0, w);

    for (int i = 0; i < 3000; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      mode  = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      gap   = $urandom_range(0, 1);
      @(posedge clk); #1;
      if (gap != 0) start = 0;
    end
    rst = 0; start = 0;
    repeat (W + 4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
